// File: rtl/spi_write_engine_if.sv
// Bus bundle for the SPI register-write engine: request inputs, MISO, and
// the registered MOSI / clock-gate / completion outputs.
interface spi_write_engine_if #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 7
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [REG_WIDTH-1:0]  wr_data;
  logic                  serial_in;
  logic                  busy;
  logic                  write_serial_out;
  logic                  write_spi_clk_en;
  logic [REG_WIDTH-1:0]  data_read_during_write;
  logic                  write_complete;

  modport master (
    output start, reg_addr, wr_data, serial_in,
    input  busy, write_serial_out, write_spi_clk_en,
    input  data_read_during_write, write_complete
  );

  modport slave (
    input  start, reg_addr, wr_data, serial_in,
    output busy, write_serial_out, write_spi_clk_en,
    output data_read_during_write, write_complete
  );
endinterface

// File: rtl/spi_write_engine.sv
// Single-register SPI write engine: shifts {1, addr, data} MSB first on MOSI
// while capturing MISO during the data phase; every output comes from a flop.
module spi_write_engine #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst,
  spi_write_engine_if.slave  bus
);

  localparam int FRAME_W = 1 + ADDR_WIDTH + REG_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_W-1:0]     shift_q, shift_d;
  logic [REG_WIDTH-1:0]   cap_q, cap_d;
  logic [REG_WIDTH-1:0]   rd_q, rd_d;
  logic                   mosi_q, mosi_d;
  logic                   clk_en_q, clk_en_d;
  logic                   busy_q, busy_d;
  logic                   wc_q, wc_d;
  logic [REG_WIDTH-1:0]   cap_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      cap_q    <= '0;
      rd_q     <= '0;
      mosi_q   <= 1'b0;
      clk_en_q <= 1'b0;
      busy_q   <= 1'b0;
      wc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      cap_q    <= cap_d;
      rd_q     <= rd_d;
      mosi_q   <= mosi_d;
      clk_en_q <= clk_en_d;
      busy_q   <= busy_d;
      wc_q     <= wc_d;
    end
  end

  // Outputs are registered from the next-state decode, so each output flop
  // already reflects the state being entered at the same edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    cap_d    = cap_q;
    rd_d     = rd_q;
    mosi_d   = 1'b0;
    clk_en_d = 1'b0;
    busy_d   = 1'b0;
    wc_d     = 1'b0;
    cap_next = {cap_q[REG_WIDTH-2:0], bus.serial_in};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = CMD;
          cnt_d    = '0;
          // The write flag goes straight to MOSI; the remainder waits in shift_q.
          shift_d  = {bus.reg_addr, bus.wr_data, 1'b0};
          cap_d    = '0;
          mosi_d   = 1'b1;
          clk_en_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      CMD: begin
        clk_en_d = 1'b1;
        busy_d   = 1'b1;
        mosi_d   = shift_q[FRAME_W-1];
        shift_d  = {shift_q[FRAME_W-2:0], 1'b0};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CMD_LAST) begin
          state_d = DATA;
        end
      end
      DATA: begin
        busy_d = 1'b1;
        cap_d  = cap_next;
        if (cnt_q == FRAME_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          wc_d    = 1'b1;
          rd_d    = cap_next;
        end else begin
          clk_en_d = 1'b1;
          mosi_d   = shift_q[FRAME_W-1];
          shift_d  = {shift_q[FRAME_W-2:0], 1'b0};
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy                   = busy_q;
  assign bus.write_serial_out       = mosi_q;
  assign bus.write_spi_clk_en       = clk_en_q;
  assign bus.write_complete         = wc_q;
  assign bus.data_read_during_write = rd_q;

endmodule

// File: doc/spi_write_engine.md
SPI_WRITE_ENGINE -- requirements
Module: spi_write_engine

Interface
REQ-001 The module SHALL have parameter REG_WIDTH, default 8, meaning the register data width in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 7, meaning the register address width in bits.
REQ-003 clk  input  1  system clock; the only clock; also the bit clock for SPI shifting.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request one register write; sampled on rising clk.
REQ-006 reg_addr  input  ADDR_WIDTH  target register address; captured at accept.
REQ-007 wr_data  input  REG_WIDTH  data to write; captured at accept.
REQ-008 serial_in  input  1  SPI MISO from target; sampled during the data phase.
REQ-009 busy  output  1  high from the cycle after accept through the DONE cycle inclusive.
REQ-010 write_serial_out  output  1  MOSI bit driven toward the SPI output mux.
REQ-011 write_spi_clk_en  output  1  SPI clock gate enable; high exactly while bits are shifted.
REQ-012 data_read_during_write  output  REG_WIDTH  MISO bits captured during the data phase.
REQ-013 write_complete  output  1  single-cycle pulse marking end of transaction; drives the mux FIFO write enable.

Function
REQ-014 The block SHALL implement states IDLE, CMD, DATA, DONE in a registered state machine.
REQ-015 Frame SHALL be {1'b1 write flag, reg_addr, wr_data}, 1+ADDR_WIDTH+REG_WIDTH bits, MSB first.
REQ-016 In IDLE, start=1 at rising edge N SHALL latch reg_addr and wr_data into a shift register and enter CMD at edge N.
REQ-017 In CMD, write_spi_clk_en SHALL be 1 and write_serial_out SHALL present one frame bit per cycle, for 1+ADDR_WIDTH cycles.
REQ-018 In DATA, write_spi_clk_en SHALL be 1, write_serial_out SHALL present wr_data bits MSB first, one per cycle, for REG_WIDTH cycles.
REQ-019 In DATA, serial_in SHALL be shifted into a capture register LSB-in each rising edge, giving the first-sampled bit as MSB.
REQ-020 A bit counter of width ceil(log2(1+ADDR_WIDTH+REG_WIDTH)) SHALL sequence phase changes; no wrap beyond the frame length.
REQ-021 With N the accept edge, write_spi_clk_en SHALL be high for cycles N+1..N+16 (defaults) and low otherwise.
REQ-022 DONE SHALL last exactly one cycle (N+17 at defaults), assert write_complete=1, and update data_read_during_write with the capture register in that same cycle.
REQ-023 data_read_during_write SHALL hold its value until the next DONE or reset.
REQ-024 From DONE the FSM SHALL return to IDLE; a new start SHALL be accepted no earlier than the first IDLE cycle (minimum 18-cycle transaction period at defaults).
REQ-025 start asserted while busy=1 SHALL be ignored, with no queuing; reg_addr/wr_data changes during busy SHALL not affect the frame.
REQ-026 Outside CMD/DATA, write_serial_out SHALL be 0 and write_spi_clk_en SHALL be 0; write_complete SHALL be 0 outside DONE.
REQ-027 All outputs SHALL be driven from registers (no combinational path from inputs to outputs).

Reset
REQ-028 rst=1 at a rising edge SHALL force state IDLE, counter 0, shift and capture registers 0.
REQ-029 During and after reset: busy=0, write_serial_out=0, write_spi_clk_en=0, write_complete=0, data_read_during_write=0.
REQ-030 Reset mid-transaction SHALL abort without a write_complete pulse; write_spi_clk_en SHALL be 0 in the cycle after the reset edge.
REQ-031 rst and start both high at the same edge: reset SHALL win; start SHALL be ignored.

Verification
REQ-032 Basic write: reg_addr=0x2A, wr_data=0xC3, serial_in stream 0x5A during DATA -> MOSI 1,0101010,11000011 over 16 enabled cycles; write_complete pulse at N+17; data_read_during_write=0x5A.
REQ-033 Busy rejection: second start with reg_addr=0x11 at N+5 -> frame unchanged, exactly one write_complete, busy continuous N+1..N+17.
REQ-034 Reset mid-DATA: rst at N+12 -> clk_en 0 from N+13, no write_complete, data_read_during_write=0x00.
REQ-035 Back-to-back: start held high continuously -> transactions accepted every 18 cycles, one-cycle clk_en gap (DONE cycle) plus IDLE cycle between frames.
REQ-036 Boundary data: wr_data=0x00 then 0xFF, serial_in constant 1 then 0 -> MOSI data bits all 0 / all 1; captures 0xFF then 0x00.
